handshake_responder: RTL
========================

// Module: handshake_responder
// PURPOSE
//  Responder end of the handshake interface: takes the dir2 modport (input port1, output port2).
//  Runs a four-phase req/ack handshake with the initiator and buffers each accepted payload in
//  a first-word-fall-through FIFO. The FIFO drains to a valid/ready stream towards the core.
//  Sits in place of a drain instance opposite a source that drives port1.
// PARAMETERS
//  WIDTH  32  handshake word width. Bit WIDTH-1 is the control flag; bits WIDTH-2:0 are the field. Minimum 2.
//  DEPTH  4   FIFO entries. Power of 2, minimum 2.
// PORTS
//  clk        input   1                    clock, rising edge
//  rst        input   1                    asynchronous, active-low reset (0 = reset)
//  inf1       modport handshake.dir2       port1 in: [WIDTH-1]=req, [WIDTH-2:0]=payload
//                                          port2 out: [WIDTH-1]=ack, [WIDTH-2:0]=accept count
//  out_valid  output  1                    FIFO non-empty
//  out_data   output  WIDTH-1              FIFO head word
//  out_ready  input   1                    downstream accepts head this cycle
//  level      output  $clog2(DEPTH+1)      FIFO occupancy
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, port2=0, FIFO empty, level=0, out_valid=0, out_data=0.
//  - port1 is synchronous to clk.
//  - The initiator holds the payload stable while req=1.
//  - full  = (level==DEPTH), taken from the registered level only.
//  FSM:
//   - IDLE: ack=0.
//     - req=1 and !full: push payload at this edge, go to ACK.
//     - req=1 and full: stay in IDLE with ack=0 (stall). No push.
//   - ACK: ack=1. The accept count is already updated.
//     - req=0: go to IDLE, ack=0 from the next cycle.
//     - req=1: stay in ACK. No further push.
//  Timing and counters:
//   - Latency: req sampled high in cycle N (not full) -> word in FIFO and ack=1 in cycle N+1.
//   - out_valid=1 from N+1 if the FIFO was empty.
//   - Accept count increments by 1 per push, modulo 2^(WIDTH-1). It wraps to 0 silently.
//  FIFO:
//   - pop = out_valid & out_ready.
//   - out_data = head and is stable while out_valid=1 and out_ready=0.
//   - Push and pop in the same cycle: level unchanged, both take effect.
//   - Full with pop, and req=1 in IDLE: pop only. Push waits one cycle, since full is registered.
//   - out_ready with empty FIFO: no effect. level never underflows.
//   - Read and write pointers wrap modulo DEPTH.
//  Reset mid-operation:
//   - Buffered words and an in-flight handshake are discarded.
//   - ack drops asynchronously.
//   - After reset release, a still-high req is treated as a new request and accepted.
// TESTING
//  1. Reset with req=1 asserted -> port2=0, out_valid=0, level=0 during reset.
//     First edge after release pushes the word, ack=1 next cycle.
//  2. Single transfer: payload 0x1234, req high one cycle-then-held -> ack=1 at N+1,
//     port2[WIDTH-2:0]=1, out_data=0x1234, out_valid=1. req=0 -> ack=0 the cycle after.
//  3. Backpressure: out_ready=0, DEPTH=4, five 4-phase requests 1..5 -> first four acked,
//     level=4. Fifth stalls with ack=0.
//     out_ready=1 one cycle -> pops 1, 5 pushed one cycle later, level=4.
//  4. Simultaneous push and pop at level=2 -> level stays 2, order preserved: 1,2,3 out in order.
//  5. Count wrap at WIDTH=4: eight transfers -> count field 1..7 then 0.
//     A ninth transfer -> 1.
//  6. Reset asserted while in ACK with level=3 -> ack=0 immediately, FIFO empty.
//     Release with req=0 -> IDLE, no spurious push.

Source files
------------

// File: rtl/handshake_responder_if.sv
// handshake: req/ack word pair between initiator (dir1) and responder (dir2)
interface handshake #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] port1;
  logic [WIDTH-1:0] port2;
  modport dir1 (output port1, input port2);
  modport dir2 (input port1, output port2);
endinterface

// File: rtl/handshake_responder.sv
// handshake_responder: four-phase req/ack responder buffering payloads in a FWFT FIFO
module handshake_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  handshake.dir2                       inf1,
  output logic                         out_valid,
  output logic [WIDTH-2:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;
  logic [WIDTH-2:0] mem [DEPTH];
  logic [WIDTH-2:0] cnt;
  logic [AW-1:0] wp, rp;
  logic req, full, push, pop;
  assign req = inf1.port1[WIDTH-1];
  assign full = level == LW'(DEPTH);
  assign pop = out_valid & out_ready;
  assign out_valid = level != '0;
  assign out_data = out_valid ? mem[rp] : '0;
  assign inf1.port2 = {state == ACK, cnt};
  always_comb begin
    push = state == IDLE && req && !full;
    state_nxt = state == IDLE ? (push ? ACK : IDLE) : (req ? ACK : IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        cnt <= cnt + 1'b1;
        wp  <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end
  // storage needs no reset: out_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= inf1.port1[WIDTH-2:0];
  end
endmodule
